// File: rtl/fpga_input_pkg.sv
// Shared types and default constants for the Nexys board input conditioner.
package fpga_input_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } rst_state_e;

  localparam int   DEF_N_INPUTS        = 7;
  localparam int   DEF_SYNC_STAGES     = 2;
  localparam int   DEF_DEBOUNCE_CYCLES = 500000;
  localparam int   DEF_RST_STRETCH     = 1024;
  localparam logic DEF_INIT_VAL        = 1'b0;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchronizer chain, stability counter and edge pulses.
module debounce_channel
  import fpga_input_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic INIT_VAL        = DEF_INIT_VAL
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic debounced_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_deb;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;
  logic                   w_diff;

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_diff      = w_sync ^ r_deb;
  assign debounced_o = r_deb;
  assign rise_o      = r_rise;
  assign fall_o      = r_fall;

  // Metastability chain for the raw asynchronous level.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync <= {SYNC_STAGES{INIT_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_deb  <= INIT_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (w_diff && (r_cnt == CNT_LAST)) begin
      r_cnt  <= '0;
      r_deb  <= w_sync;
      r_rise <= w_sync;
      r_fall <= ~w_sync;
    end else if (w_diff) begin
      r_cnt  <= r_cnt + CNT_ONE;
      r_deb  <= r_deb;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= '0;
      r_deb  <= r_deb;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

endmodule

// File: rtl/nexys_input_conditioner.sv
// Board input conditioning: debounced switches/buttons plus a stretched SoC reset.
module nexys_input_conditioner
  import fpga_input_pkg::*;
#(
  parameter int   N_INPUTS        = DEF_N_INPUTS,
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   RST_STRETCH     = DEF_RST_STRETCH,
  parameter logic INIT_VAL        = DEF_INIT_VAL
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_INPUTS-1:0] raw_i,
  input  logic                rst_btn_ni,
  output logic [N_INPUTS-1:0] debounced_o,
  output logic [N_INPUTS-1:0] rise_o,
  output logic [N_INPUTS-1:0] fall_o,
  output logic                soc_rst_no
);

  localparam int               STR_W    = cnt_width(RST_STRETCH);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(RST_STRETCH - 1);
  localparam logic [STR_W-1:0] STR_ONE  = STR_W'(1);

  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic                   w_btn;
  rst_state_e             r_state;
  logic [STR_W-1:0]       r_str_cnt;
  logic                   r_soc_rst_n;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_VAL       (INIT_VAL)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .raw_i      (raw_i[g]),
      .debounced_o(debounced_o[g]),
      .rise_o     (rise_o[g]),
      .fall_o     (fall_o[g])
    );
  end

  assign w_btn      = r_btn_sync[SYNC_STAGES-1];
  assign soc_rst_no = r_soc_rst_n;

  // Button synchronizer resets to "pressed" so the SoC waits for a real release.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_btn_sync <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], rst_btn_ni};
    end
  end

  // Reset stretcher: any press re-asserts at once, release must hold RST_STRETCH cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_ASSERT;
      r_str_cnt   <= '0;
      r_soc_rst_n <= 1'b0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          r_str_cnt   <= '0;
          r_soc_rst_n <= 1'b0;
          if (w_btn) begin
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_ASSERT;
          end
        end
        ST_HOLD: begin
          if (!w_btn) begin
            r_state     <= ST_ASSERT;
            r_str_cnt   <= '0;
            r_soc_rst_n <= 1'b0;
          end else if (r_str_cnt == STR_LAST) begin
            r_state     <= ST_RUN;
            r_str_cnt   <= '0;
            r_soc_rst_n <= 1'b1;
          end else begin
            r_state     <= ST_HOLD;
            r_str_cnt   <= r_str_cnt + STR_ONE;
            r_soc_rst_n <= 1'b0;
          end
        end
        ST_RUN: begin
          r_str_cnt <= '0;
          if (!w_btn) begin
            r_state     <= ST_ASSERT;
            r_soc_rst_n <= 1'b0;
          end else begin
            r_state     <= ST_RUN;
            r_soc_rst_n <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_ASSERT;
          r_str_cnt   <= '0;
          r_soc_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nexys_input_conditioner.md
NEXYS_INPUT_CONDITIONER -- requirements
Module: nexys_input_conditioner

Interface
REQ-001 SHALL have parameter N_INPUTS, default 7, number of debounced board inputs (2 switches, 5 buttons).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth; legal range 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable cycles required before accepting a change; minimum 2.
REQ-004 SHALL have parameter RST_STRETCH, default 1024, cycles the SoC reset is held after button release; minimum 1.
REQ-005 SHALL have parameter INIT_VAL, default 1'b0, reset level of every synchronizer flop and debounced output.
REQ-006 clk_i  input  1  board reference clock; the single clock of the block.
REQ-007 rst_ni  input  1  synchronous, active-low reset.
REQ-008 raw_i  input  N_INPUTS  asynchronous raw switch/button levels.
REQ-009 rst_btn_ni  input  1  asynchronous raw board reset button, active-low.
REQ-010 debounced_o  output  N_INPUTS  debounced levels; these drive the SoC cam_data pads.
REQ-011 rise_o  output  N_INPUTS  one-cycle pulse on debounced 0->1.
REQ-012 fall_o  output  N_INPUTS  one-cycle pulse on debounced 1->0.
REQ-013 soc_rst_no  output  1  stretched active-low reset; drives the SoC pad_reset_n.

Function
REQ-014 Each raw_i bit and rst_btn_ni SHALL pass through a SYNC_STAGES flop chain; raw change appears at the chain output after exactly SYNC_STAGES rising edges.
REQ-015 Per channel, two states: STABLE (sync == debounced, counter 0) and COUNTING (sync != debounced).
REQ-016 COUNTING: counter SHALL increment by 1 each cycle sync differs from debounced; counter width = clog2(DEBOUNCE_CYCLES).
REQ-017 When counter == DEBOUNCE_CYCLES-1 and sync still differs, next edge SHALL load debounced from sync, clear counter, return to STABLE.
REQ-018 If sync equals debounced in any COUNTING cycle, counter SHALL clear the next edge (return to STABLE) with no output change.
REQ-019 Total latency raw_i change -> debounced_o change SHALL be SYNC_STAGES + DEBOUNCE_CYCLES edges for a clean step.
REQ-020 rise_o/fall_o SHALL be high in exactly the cycle debounced_o first shows its new value, for one cycle only.
REQ-021 Channels SHALL be independent; simultaneous changes on any subset produce independent, concurrent pulses.
REQ-022 Counter SHALL never wrap; saturation is impossible given REQ-017.
REQ-023 Reset FSM states: ASSERT, HOLD, RUN; soc_rst_no SHALL be 0 in ASSERT and HOLD, 1 in RUN (registered output).
REQ-024 ASSERT -> HOLD when synchronized button reads 1; stretch counter cleared on entry.
REQ-025 HOLD: stretch counter increments each cycle; at RST_STRETCH-1 -> RUN next edge.
REQ-026 Synchronized button 0 in HOLD or RUN SHALL go to ASSERT next edge regardless of duration (no debounce on reset press), clearing stretch counter.
REQ-027 Button release to soc_rst_no rising SHALL be SYNC_STAGES + 1 + RST_STRETCH edges.

Reset
REQ-028 While rst_ni low at a rising edge: synchronizers and debounced_o = INIT_VAL, all counters 0, rise_o = fall_o = 0, reset FSM = ASSERT, soc_rst_no = 0.
REQ-029 rst_ni asserted mid-count SHALL abandon the pending change without emitting a pulse.
REQ-030 Synchronizer for rst_btn_ni SHALL reset to 0 (pressed), so soc_rst_no stays low until a real release is seen.

Structure
REQ-031 Shared package fpga_input_pkg SHALL hold the reset-FSM state enum (ASSERT/HOLD/RUN) and default parameter constants.
REQ-032 Per-channel sync + debounce logic SHALL be sub-module debounce_channel, instantiated N_INPUTS times by generate; reset FSM stays in the top.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, RST_STRETCH=16, INIT_VAL=0)
REQ-033 Clean step raw_i[3] 0->1 -> debounced_o[3]=1 exactly 10 edges later, rise_o[3] high that cycle only, other bits unchanged.
REQ-034 Glitch raw_i[0]=1 for 5 cycles then 0 -> debounced_o[0] stays 0, no rise_o/fall_o pulse.
REQ-035 Bounce raw_i[1] toggling every 3 cycles for 30 cycles then held 1 -> exactly one rise_o[1], 10 edges after the final toggle.
REQ-036 rst_btn_ni released after reset -> soc_rst_no=1 after 19 edges; 1-cycle press at stretch count 10 -> soc_rst_no stays 0, rises 19 edges after that press ends.
REQ-037 rst_ni pulsed low at counter=5 during a 0->1 change on raw_i[2] -> debounced_o[2]=0, no pulse, full 10-edge latency re-measured after reset.
REQ-038 All 7 raw_i bits stepped 0->1 in one cycle -> all debounced_o and rise_o bits assert in the same cycle, 10 edges later.
